// File: rtl/blink_pkg.sv
// Shared mode encodings and FSM state type for the LED blink controller.
package blink_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON_PH  = 2'd1,
        OFF_PH = 2'd2
    } state_t;

endpackage

// File: rtl/blink_prescaler.sv
// Divides the clock into one-cycle phase ticks, one every DIV enabled cycles.
// tick is decoded from the counter so it lines up with the DIV-th cycle after a clear.
module blink_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] pc;

    assign tick = en && (pc == PW'(DIV - 1));

    // Count enabled cycles, wrapping on tick; held at zero while disabled or cleared.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc <= '0;
        end else if (sync_clr || !en || tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PW'(1);
        end
    end

endmodule

// File: rtl/blink_ctrl.sv
// LED sequence controller: OFF / SOLID / BLINK / BURST with registered outputs.
// The FSM, phase counter and burst counter live here; the prescaler supplies ticks.
module blink_ctrl
    import blink_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] half_period,
    input  logic [CNT_W-1:0] burst_len,
    output logic             led,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] bcnt, bcnt_nxt;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] hp_q;
    logic [CNT_W-1:0] bl_q;
    logic             done_nxt;
    logic             load;
    logic             presc_clr;
    logic             tick;

    blink_prescaler #(.DIV(DIV)) u_presc (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (busy),
        .sync_clr (presc_clr),
        .tick     (tick)
    );

    // Next-state, counter and done decode; stop always wins over start and ticks.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bcnt_nxt  = bcnt;
        done_nxt  = 1'b0;
        load      = 1'b0;
        presc_clr = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    load      = 1'b1;
                    presc_clr = 1'b1;
                    cnt_nxt   = '0;
                    bcnt_nxt  = '0;
                    case (mode)
                        // OFF spends a single busy cycle in OFF_PH so led stays low.
                        MODE_OFF:   state_nxt = OFF_PH;
                        MODE_BURST: begin
                            if (burst_len == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                state_nxt = ON_PH;
                            end
                        end
                        default:    state_nxt = ON_PH;
                    endcase
                end
            end
            ON_PH, OFF_PH: begin
                if (stop) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    bcnt_nxt  = '0;
                    presc_clr = 1'b1;
                end else if (mode_q == MODE_OFF) begin
                    state_nxt = IDLE;
                end else if (mode_q == MODE_SOLID) begin
                    state_nxt = ON_PH;
                end else if (tick) begin
                    if (cnt == hp_q - CNT_W'(1)) begin
                        cnt_nxt = '0;
                        if (state == ON_PH) begin
                            state_nxt = OFF_PH;
                        end else if (mode_q == MODE_BURST &&
                                     (bcnt + CNT_W'(1)) == bl_q) begin
                            // bcnt never exceeds bl_q-1, so the increment cannot wrap.
                            state_nxt = IDLE;
                            bcnt_nxt  = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ON_PH;
                            if (mode_q == MODE_BURST) begin
                                bcnt_nxt = bcnt + CNT_W'(1);
                            end
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                bcnt_nxt  = '0;
            end
        endcase
    end

    // State, counters and outputs register together so led/busy track the state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            cnt   <= '0;
            bcnt  <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bcnt  <= bcnt_nxt;
            led   <= (state_nxt == ON_PH);
            busy  <= (state_nxt != IDLE);
            done  <= done_nxt;
        end
    end

    // Capture the sequence configuration when a start is accepted; half_period 0 acts as 1.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mode_q <= MODE_OFF;
            hp_q   <= CNT_W'(1);
            bl_q   <= '0;
        end else if (load) begin
            mode_q <= mode;
            hp_q   <= (half_period == '0) ? CNT_W'(1) : half_period;
            bl_q   <= burst_len;
        end
    end

endmodule

// File: tb/tb_blink_ctrl.sv
// Bench for blink_ctrl: table of sequence vectors with a closed-form expected
// waveform pushed to a scoreboard queue and compared one cycle later.
module tb_blink_ctrl;

    localparam int DIV   = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] burst_len;
    logic             led;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;

    blink_ctrl #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .half_period (half_period),
        .burst_len   (burst_len),
        .led         (led),
        .cnt         (cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             led;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] cnt;
    } out_t;

    typedef struct {
        int mode;
        int hp;
        int bl;
        int n;        // cycles observed after the start cycle
        int stop_at;  // cycle index with stop high, -1 none
        int s2_at;    // cycle index with a second (SOLID) start, -1 none
    } vec_t;

    typedef struct {
        out_t exp;
        int   vid;
        int   t;
    } sb_t;

    vec_t tbl[11];
    sb_t  sbq[$];
    int   checks = 0;
    int   errs   = 0;

    function automatic out_t cur_out();
        out_t o;
        o = {led, busy, done, cnt};
        return o;
    endfunction

    // Expected outputs t cycles after the start cycle, from phase arithmetic.
    function automatic out_t model(vec_t v, int t);
        out_t o;
        int hpe, p, fin;
        o = '0;
        if (v.stop_at >= 0 && t > v.stop_at) return o;
        hpe = (v.hp == 0) ? 1 : v.hp;
        p   = hpe * DIV;
        case (v.mode)
            0: if (t == 1) o.busy = 1'b1;
            1: begin o.led = 1'b1; o.busy = 1'b1; end
            2: begin
                o.busy = 1'b1;
                o.led  = (((t - 1) / p) % 2) == 0;
                o.cnt  = CNT_W'(((t - 1) % p) / DIV);
            end
            default: begin
                fin = 2 * v.bl * p + 1;
                if (t < fin) begin
                    o.busy = 1'b1;
                    o.led  = (((t - 1) / p) % 2) == 0;
                    o.cnt  = CNT_W'(((t - 1) % p) / DIV);
                end else if (t == fin) begin
                    o.done = 1'b1;
                end
            end
        endcase
        return o;
    endfunction

    task automatic chk(string name, int vid, int t, out_t act, out_t exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s v%0d t%0d: got led=%0b busy=%0b done=%0b cnt=%0d, want led=%0b busy=%0b done=%0b cnt=%0d",
                     name, vid, t, act.led, act.busy, act.done, act.cnt,
                     exp.led, exp.busy, exp.done, exp.cnt);
        end
    endtask

    // Scoreboard consumer: compare one queued expectation per clock edge.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("seq", e.vid, e.t, cur_out(), e.exp);
        end
    end

    task automatic run_vec(int vi);
        vec_t v;
        sb_t  e;
        v = tbl[vi];
        for (int c = 0; c <= v.n; c++) begin
            @(negedge clk);
            stop = (c == v.stop_at);
            if (c == 0) begin
                start       = 1'b1;
                mode        = 2'(v.mode);
                half_period = CNT_W'(v.hp);
                burst_len   = CNT_W'(v.bl);
            end else if (c == v.s2_at) begin
                start       = 1'b1;
                mode        = 2'd1;
                half_period = CNT_W'(7);
                burst_len   = CNT_W'(1);
            end else begin
                start       = 1'b0;
                mode        = 2'($urandom_range(0, 3));
                half_period = CNT_W'($urandom_range(0, 15));
                burst_len   = CNT_W'($urandom_range(0, 15));
            end
            if (c < v.n) begin
                e.exp = model(v, c + 1);
                e.vid = vi;
                e.t   = c + 1;
                sbq.push_back(e);
            end
        end
        // Stop returns any live sequence to IDLE; a further stop in IDLE changes nothing.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b1;
            e.exp = '0;
            e.vid = vi;
            e.t   = v.n + 1 + k;
            sbq.push_back(e);
        end
        @(negedge clk);
        stop = 1'b0;
        e.exp = '0;
        e.t   = v.n + 3;
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        out_t z, on0;
        z   = '0;
        on0 = '0;
        on0.led  = 1'b1;
        on0.busy = 1'b1;

        tbl[0]  = '{mode: 3, hp: 3,  bl: 2,  n: 55,  stop_at: -1,  s2_at: -1};
        tbl[1]  = '{mode: 2, hp: 0,  bl: 0,  n: 33,  stop_at: 30,  s2_at: -1};
        tbl[2]  = '{mode: 2, hp: 2,  bl: 5,  n: 40,  stop_at: -1,  s2_at: 5};
        tbl[3]  = '{mode: 2, hp: 1,  bl: 0,  n: 5,   stop_at: 0,   s2_at: -1};
        tbl[4]  = '{mode: 3, hp: 2,  bl: 0,  n: 6,   stop_at: -1,  s2_at: -1};
        tbl[5]  = '{mode: 0, hp: 3,  bl: 3,  n: 4,   stop_at: -1,  s2_at: -1};
        tbl[6]  = '{mode: 1, hp: 5,  bl: 0,  n: 20,  stop_at: 15,  s2_at: -1};
        tbl[7]  = '{mode: 3, hp: 1,  bl: 15, n: 125, stop_at: -1,  s2_at: -1};
        tbl[8]  = '{mode: 2, hp: 15, bl: 0,  n: 130, stop_at: 128, s2_at: -1};
        tbl[9]  = '{mode: 3, hp: 2,  bl: 3,  n: 25,  stop_at: 20,  s2_at: -1};
        tbl[10] = '{mode: 3, hp: 1,  bl: 1,  n: 12,  stop_at: 8,   s2_at: -1};

        clr_n       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        mode        = 2'd0;
        half_period = '0;
        burst_len   = '0;
        #2;
        chk("reset", -1, 0, cur_out(), z);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i);

        // Asynchronous reset in the middle of ON_PH, between clock edges.
        @(negedge clk);
        start       = 1'b1;
        mode        = 2'd2;
        half_period = CNT_W'(3);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #3;
        chk("pre_reset_on", -1, 2, cur_out(), on0);
        clr_n = 1'b0;
        #1;
        chk("async_reset", -1, 2, cur_out(), z);
        @(posedge clk);
        #1;
        chk("reset_held", -1, 3, cur_out(), z);
        @(negedge clk);
        clr_n = 1'b1;

        // Clean sequence after reset release.
        run_vec(0);

        repeat (3) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
